// File: rtl/mem_burst_master_pkg.sv
// ============================================================================
// mem_burst_master_pkg : shared FSM state, burst size codes, size decoding
// Revision 1.0
// ============================================================================
`default_nettype none

package mem_burst_master_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RD_REQ  = 3'd1,
      RD_WAIT = 3'd2,
      RD_DATA = 3'd3,
      WR_BEAT = 3'd4,
      DONE    = 3'd5
   } state_t;

   localparam logic [1:0] SZ_1W  = 2'b00;
   localparam logic [1:0] SZ_4W  = 2'b01;
   localparam logic [1:0] SZ_8W  = 2'b10;
   localparam logic [1:0] SZ_16W = 2'b11;

   function automatic logic [4:0] size_to_beats(input logic [1:0] code);
      logic [4:0] beats;
      case (code)
         SZ_1W:   beats = 5'd1;
         SZ_4W:   beats = 5'd4;
         SZ_8W:   beats = 5'd8;
         default: beats = 5'd16;
      endcase
      return beats;
   endfunction

endpackage

`default_nettype wire

// File: rtl/mem_burst_master_addr_gen.sv
// ============================================================================
// burst_addr_gen : holds burst base, beat counter and last-beat flag
// Revision 1.0
// ============================================================================
`default_nettype none

module burst_addr_gen
   import mem_burst_master_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              load,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [1:0]        load_size,
   input  logic              step,
   output logic [ADDR_W-1:0] beat_addr,
   output logic              last_beat
);

   logic [ADDR_W-1:0] base_addr;
   logic [4:0]        num_beats;
   logic [4:0]        beat_cnt;

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         base_addr <= '0;
         num_beats <= '0;
         beat_cnt  <= '0;
      end else if (load) begin
         base_addr <= load_addr;
         num_beats <= size_to_beats(load_size);
         beat_cnt  <= '0;
      end else if (step) begin
         beat_cnt  <= beat_cnt + 5'd1;
      end
   end

   // Word offset wraps modulo 2^ADDR_W along with the base.
   assign beat_addr = base_addr + {{(ADDR_W-7){1'b0}}, beat_cnt, 2'b00};
   assign last_beat = (beat_cnt == (num_beats - 5'd1));

endmodule

`default_nettype wire

// File: rtl/mem_burst_master.sv
// ============================================================================
// mem_burst_master : single-outstanding burst initiator for main memory
// Revision 1.0
// ============================================================================
`default_nettype none

module mem_burst_master
   import mem_burst_master_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [1:0]        req_size,
   input  logic              req_rw,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_valid,
   output logic              wr_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              rd_last,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_data_in,
   output logic [1:0]        mem_access_size,
   output logic              mem_rw,
   output logic              mem_enable,
   input  logic              mem_busy,
   input  logic [DATA_W-1:0] mem_data_out
);

   state_t            state;
   state_t            state_nxt;
   logic              accept;
   logic              misaligned;
   logic              load;
   logic              wr_fire;
   logic              step;
   logic              last_beat;
   logic [ADDR_W-1:0] beat_addr;
   logic [1:0]        wait_cnt;
   logic              rd_req_en;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic [1:0]        size_q;
   logic              rw_q;

   // A read's done lands in the first IDLE cycle, so hold off new requests then.
   assign req_ready  = (state == IDLE) && !done;
   assign accept     = req_valid && req_ready;
   assign misaligned = |req_addr[1:0];
   assign load       = accept && !misaligned;
   assign wr_fire    = (state == WR_BEAT) && wr_valid && !mem_busy;
   assign wr_ready   = wr_fire;
   assign step       = (state == RD_DATA) || wr_fire;

   burst_addr_gen #(
      .ADDR_W (ADDR_W)
   ) u_addr_gen (
      .clock     (clock),
      .reset_n   (reset_n),
      .load      (load),
      .load_addr (req_addr),
      .load_size (req_size),
      .step      (step),
      .beat_addr (beat_addr),
      .last_beat (last_beat)
   );

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (load) begin
               state_nxt = req_rw ? WR_BEAT : RD_REQ;
            end
         end
         RD_REQ: begin
            if (!mem_busy) begin
               state_nxt = (RD_LAT == 1) ? RD_DATA : RD_WAIT;
            end
         end
         RD_WAIT: begin
            if (wait_cnt == 2'(RD_LAT - 2)) begin
               state_nxt = RD_DATA;
            end
         end
         RD_DATA: begin
            if (last_beat) begin
               state_nxt = DONE;
            end
         end
         WR_BEAT: begin
            if (wr_fire && last_beat) begin
               state_nxt = DONE;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         wait_cnt  <= '0;
         rd_req_en <= 1'b0;
         addr_q    <= '0;
         wdata_q   <= '0;
         size_q    <= '0;
         rw_q      <= 1'b0;
         rd_data   <= '0;
         rd_valid  <= 1'b0;
         rd_last   <= 1'b0;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         wait_cnt <= (state == RD_WAIT) ? wait_cnt + 2'd1 : 2'd0;
         err      <= accept && misaligned;
         // Write done follows the final beat; read done follows rd_last.
         done     <= (wr_fire && last_beat) || ((state == DONE) && !rw_q);
         rd_valid <= (state == RD_DATA);
         rd_last  <= (state == RD_DATA) && last_beat;
         if (state == RD_DATA) begin
            rd_data <= mem_data_out;
         end
         if (load) begin
            rd_req_en <= !req_rw;
            addr_q    <= req_addr;
            size_q    <= req_size;
            rw_q      <= req_rw;
         end else if ((state == RD_REQ) && !mem_busy) begin
            rd_req_en <= 1'b0;
         end
         if (wr_fire) begin
            addr_q  <= beat_addr;
            wdata_q <= wr_data;
            size_q  <= SZ_1W;
            rw_q    <= 1'b1;
         end
      end
   end

   // Write beats drive the port directly from inputs; otherwise registered values hold.
   assign mem_enable      = rd_req_en || wr_fire;
   assign mem_rw          = wr_fire ? 1'b1      : rw_q;
   assign mem_address     = wr_fire ? beat_addr : addr_q;
   assign mem_data_in     = wr_fire ? wr_data   : wdata_q;
   assign mem_access_size = wr_fire ? SZ_1W     : size_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_burst_master.sv
// ============================================================================
// tb_mem_burst_master : directed self-checking bench for mem_burst_master
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_mem_burst_master;

   logic        clock = 1'b0;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic [31:0] req_addr;
   logic [1:0]  req_size;
   logic        req_rw;
   logic [31:0] wr_data;
   logic        wr_valid;
   logic        wr_ready;
   logic [31:0] rd_data;
   logic        rd_valid;
   logic        rd_last;
   logic        done;
   logic        err;
   logic [31:0] mem_address;
   logic [31:0] mem_data_in;
   logic [1:0]  mem_access_size;
   logic        mem_rw;
   logic        mem_enable;
   logic        mem_busy;
   logic [31:0] mem_data_out;

   int n_vec = 0;
   int n_bad = 0;

   // Memory read model: word k of a burst appears k+1 cycles after acceptance.
   logic [31:0] mem_seed   = 32'h0;
   logic [31:0] mem_idx    = 32'h0;
   logic        mem_stream = 1'b0;

   always @(posedge clock) begin
      if (mem_enable && !mem_rw && !mem_busy) begin
         mem_stream <= 1'b1;
         mem_idx    <= 32'h0;
      end else if (mem_stream) begin
         mem_idx    <= mem_idx + 32'h1;
      end
   end
   assign mem_data_out = mem_seed + mem_idx;

   always #5 clock = ~clock;

   mem_burst_master #(
      .ADDR_W (32),
      .DATA_W (32),
      .RD_LAT (1)
   ) dut (
      .clock           (clock),
      .reset_n         (reset_n),
      .req_valid       (req_valid),
      .req_ready       (req_ready),
      .req_addr        (req_addr),
      .req_size        (req_size),
      .req_rw          (req_rw),
      .wr_data         (wr_data),
      .wr_valid        (wr_valid),
      .wr_ready        (wr_ready),
      .rd_data         (rd_data),
      .rd_valid        (rd_valid),
      .rd_last         (rd_last),
      .done            (done),
      .err             (err),
      .mem_address     (mem_address),
      .mem_data_in     (mem_data_in),
      .mem_access_size (mem_access_size),
      .mem_rw          (mem_rw),
      .mem_enable      (mem_enable),
      .mem_busy        (mem_busy),
      .mem_data_out    (mem_data_out)
   );

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset;
      reset_n   = 1'b0;
      req_valid = 1'b0;
      req_addr  = 32'h0;
      req_size  = 2'b00;
      req_rw    = 1'b0;
      wr_data   = 32'h0;
      wr_valid  = 1'b0;
      mem_busy  = 1'b0;
      tick();
      tick();
      n_vec++;
      if ({rd_valid, rd_last, done, err, mem_enable, mem_rw, wr_ready} !== 7'b0) begin
         n_bad++;
         $display("FAIL reset_flags got %b exp 0000000",
                  {rd_valid, rd_last, done, err, mem_enable, mem_rw, wr_ready});
      end
      n_vec++;
      if ({rd_data, mem_address, mem_data_in, mem_access_size} !== 98'b0) begin
         n_bad++;
         $display("FAIL reset_data got rd=%h a=%h d=%h s=%b exp all zero",
                  rd_data, mem_address, mem_data_in, mem_access_size);
      end
      n_vec++;
      if (req_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL reset_req_ready got %b exp 1", req_ready);
      end
      reset_n = 1'b1;
      tick();
   endtask

   // Read burst; busy held for nbusy RD_REQ cycles, then toggled during data to show it is ignored.
   task automatic run_read(input string name, input logic [31:0] addr, input logic [1:0] size,
                           input logic [31:0] seed, input int nbusy, input int nbeats);
      mem_seed  = seed;
      req_valid = 1'b1;
      req_addr  = addr;
      req_size  = size;
      req_rw    = 1'b0;
      mem_busy  = (nbusy > 0);
      tick();
      req_valid = 1'b0;
      for (int i = 0; i < nbusy; i++) begin
         n_vec++;
         if (mem_enable !== 1'b1 || req_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL %s busy_hold cyc %0d got en=%b rdy=%b exp en=1 rdy=0",
                     name, i, mem_enable, req_ready);
         end
         tick();
      end
      mem_busy = 1'b0;
      n_vec++;
      if (mem_enable !== 1'b1 || mem_rw !== 1'b0 || mem_address !== addr || mem_access_size !== size) begin
         n_bad++;
         $display("FAIL %s rd_req got en=%b rw=%b a=%h s=%b exp en=1 rw=0 a=%h s=%b",
                  name, mem_enable, mem_rw, mem_address, mem_access_size, addr, size);
      end
      tick();
      n_vec++;
      if (rd_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL %s early_valid got %b exp 0", name, rd_valid);
      end
      tick();
      for (int b = 0; b < nbeats; b++) begin
         mem_busy = (b % 2 == 1);
         n_vec++;
         if (rd_valid !== 1'b1 || rd_data !== seed + 32'(b) || rd_last !== (b == nbeats - 1)
             || done !== 1'b0 || mem_enable !== 1'b0) begin
            n_bad++;
            $display("FAIL %s beat %0d got v=%b d=%h l=%b dn=%b en=%b exp v=1 d=%h l=%b dn=0 en=0",
                     name, b, rd_valid, rd_data, rd_last, done, mem_enable,
                     seed + 32'(b), (b == nbeats - 1));
         end
         tick();
      end
      mem_busy = 1'b0;
      n_vec++;
      if (done !== 1'b1 || rd_valid !== 1'b0 || req_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL %s done got dn=%b v=%b rdy=%b exp dn=1 v=0 rdy=0", name, done, rd_valid, req_ready);
      end
      tick();
      n_vec++;
      if (done !== 1'b0 || req_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL %s idle got dn=%b rdy=%b exp dn=0 rdy=1", name, done, req_ready);
      end
   endtask

   task automatic run_write(input string name, input logic [31:0] base, input logic [1:0] size,
                            input logic [15:0] vpat, input int plen, input int nbeats);
      int k = 0;
      logic [31:0] exp_a;
      req_valid = 1'b1;
      req_addr  = base;
      req_size  = size;
      req_rw    = 1'b1;
      tick();
      req_valid = 1'b0;
      for (int c = 0; c < plen; c++) begin
         wr_valid = vpat[c];
         wr_data  = 32'hA5000000 + 32'(k);
         exp_a    = base + 32'(k * 4);
         #1;
         n_vec++;
         if (vpat[c]) begin
            if (mem_enable !== 1'b1 || wr_ready !== 1'b1 || mem_rw !== 1'b1 || mem_address !== exp_a
                || mem_data_in !== wr_data || mem_access_size !== 2'b00) begin
               n_bad++;
               $display("FAIL %s beat %0d got en=%b wr=%b rw=%b a=%h d=%h s=%b exp en=1 wr=1 rw=1 a=%h d=%h s=00",
                        name, k, mem_enable, wr_ready, mem_rw, mem_address, mem_data_in,
                        mem_access_size, exp_a, wr_data);
            end
         end else begin
            if (mem_enable !== 1'b0 || wr_ready !== 1'b0 || done !== 1'b0) begin
               n_bad++;
               $display("FAIL %s gap cyc %0d got en=%b wr=%b dn=%b exp 0 0 0",
                        name, c, mem_enable, wr_ready, done);
            end
         end
         tick();
         if (vpat[c]) k++;
      end
      n_vec++;
      if (k !== nbeats) begin
         n_bad++;
         $display("FAIL %s beat_count got %0d exp %0d", name, k, nbeats);
      end
      wr_valid = 1'b1;
      #1;
      n_vec++;
      if (done !== 1'b1 || wr_ready !== 1'b0 || mem_enable !== 1'b0 || req_ready !== 1'b0) begin
         n_bad++;
         $display("FAIL %s done got dn=%b wr=%b en=%b rdy=%b exp dn=1 wr=0 en=0 rdy=0",
                  name, done, wr_ready, mem_enable, req_ready);
      end
      wr_valid = 1'b0;
      tick();
      n_vec++;
      if (done !== 1'b0 || req_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL %s idle got dn=%b rdy=%b exp dn=0 rdy=1", name, done, req_ready);
      end
   endtask

   task automatic test_read_single;
      run_read("rd1", 32'h00000100, 2'b00, 32'hDEADBEEF, 0, 1);
   endtask

   task automatic test_read_busy16;
      run_read("rd16", 32'h00000300, 2'b11, 32'h10000000, 3, 16);
   endtask

   task automatic test_write_gapped;
      run_write("wr4", 32'h00000200, 2'b01, 16'b101101, 6, 4);
   endtask

   task automatic test_misaligned;
      req_valid = 1'b1;
      req_addr  = 32'h00000102;
      req_size  = 2'b00;
      req_rw    = 1'b0;
      tick();
      req_valid = 1'b0;
      n_vec++;
      if (err !== 1'b1 || mem_enable !== 1'b0 || req_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL misalign_pulse got err=%b en=%b rdy=%b exp err=1 en=0 rdy=1",
                  err, mem_enable, req_ready);
      end
      tick();
      n_vec++;
      if (err !== 1'b0 || mem_enable !== 1'b0 || req_ready !== 1'b1 || rd_valid !== 1'b0) begin
         n_bad++;
         $display("FAIL misalign_after got err=%b en=%b rdy=%b v=%b exp 0 0 1 0",
                  err, mem_enable, req_ready, rd_valid);
      end
   endtask

   task automatic test_write_wrap;
      run_write("wr8wrap", 32'hFFFFFFF8, 2'b10, 16'h00FF, 8, 8);
   endtask

   task automatic test_back_to_back;
      run_read("rd4", 32'h00000400, 2'b01, 32'h55AA0000, 0, 4);
   endtask

   task automatic test_reset_mid_read;
      mem_seed  = 32'h77000000;
      req_valid = 1'b1;
      req_addr  = 32'h00000800;
      req_size  = 2'b10;
      req_rw    = 1'b0;
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      for (int b = 0; b < 5; b++) begin
         n_vec++;
         if (rd_valid !== 1'b1 || rd_data !== 32'h77000000 + 32'(b)) begin
            n_bad++;
            $display("FAIL rst_mid beat %0d got v=%b d=%h exp v=1 d=%h",
                     b, rd_valid, rd_data, 32'h77000000 + 32'(b));
         end
         if (b < 4) tick();
      end
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      n_vec++;
      if ({rd_valid, rd_last, done, err, mem_enable, mem_rw, wr_ready} !== 7'b0
          || rd_data !== 32'h0 || mem_address !== 32'h0 || req_ready !== 1'b1) begin
         n_bad++;
         $display("FAIL rst_mid_outputs got flags=%b rd=%h a=%h rdy=%b exp flags=0 rd=0 a=0 rdy=1",
                  {rd_valid, rd_last, done, err, mem_enable, mem_rw, wr_ready},
                  rd_data, mem_address, req_ready);
      end
      for (int i = 0; i < 4; i++) begin
         tick();
         n_vec++;
         if (done !== 1'b0 || mem_enable !== 1'b0 || rd_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_quiet cyc %0d got dn=%b en=%b v=%b exp 0 0 0",
                     i, done, mem_enable, rd_valid);
         end
      end
   endtask

   initial begin
      test_reset();
      test_read_single();
      test_read_busy16();
      test_write_gapped();
      test_misaligned();
      test_write_wrap();
      test_back_to_back();
      test_reset_mid_read();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

`default_nettype wire
